// File: rtl/frog_game_pkg.sv
// Shared definitions for the frog game pixel pipeline: coordinate width and
// the collision detector state encoding.
package frog_game_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    REPORT  = 2'd2,
    HOLDOFF = 2'd3
  } coll_state_t;

endpackage

// File: rtl/coord_delay_pipe.sv
// Fixed-depth shift register that re-times a coordinate to match registered
// drawer outputs. DEPTH=0 degenerates to a wire.
module coord_delay_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 11
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/gate_collision_detect.sv
// Frog vs gate A / border overlap detector: latches overlaps per frame, reports
// them as one-cycle pulses after the frame, then suppresses repeats for a hold-off.
//
//   state   | meaning
//   IDLE    | game stopped, waiting for a frame start with enable high
//   SCAN    | accumulating overlap flags for the current frame
//   REPORT  | one cycle: pulse last frame's flags, bump the hit counter
//   HOLDOFF | overlaps ignored while the frame hold-off counts down
module gate_collision_detect #(
  parameter int COORD_W        = frog_game_pkg::COORD_W,
  parameter int DRAW_LATENCY   = 1,
  parameter int HOLDOFF_FRAMES = 30,
  parameter int COUNT_W        = 8
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               enable,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] oCoord_X,
  input  logic [COORD_W-1:0] oCoord_Y,
  input  logic               gateA_draw_req,
  input  logic               frog_draw_req,
  input  logic               border_draw_req,
  input  logic               clear_count,
  output logic               collision_gate,
  output logic               collision_border,
  output logic [COUNT_W-1:0] gate_hit_count,
  output logic [COORD_W-1:0] hit_X,
  output logic [COORD_W-1:0] hit_Y
);
  import frog_game_pkg::*;

  localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_FRAMES);

  logic [COORD_W-1:0] x_al, y_al;
  logic               gate_hit, border_hit, frame_start, accumulate;

  coll_state_t        state_q, state_d;
  logic               gflag_q, gflag_d, bflag_q, bflag_d;
  logic               rep_g_q, rep_g_d, rep_b_q, rep_b_d;
  logic               coll_g_q, coll_g_d, coll_b_q, coll_b_d;
  logic [COORD_W-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [COORD_W-1:0] hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  coord_delay_pipe #(.DEPTH(DRAW_LATENCY), .W(COORD_W)) u_dly_x (
    .CLK(CLK), .RESETn(RESETn), .d_i(oCoord_X), .q_o(x_al));
  coord_delay_pipe #(.DEPTH(DRAW_LATENCY), .W(COORD_W)) u_dly_y (
    .CLK(CLK), .RESETn(RESETn), .d_i(oCoord_Y), .q_o(y_al));

  assign gate_hit   = gateA_draw_req & frog_draw_req;
  assign border_hit = border_draw_req & frog_draw_req;

  // A frame start both closes the old frame and samples the first pixel of the new one.
  assign frame_start = enable & startOfFrame &
                       ((state_q == SCAN) | ((state_q == HOLDOFF) & (hold_q == HOLD_W'(1))));
  assign accumulate  = enable & (((state_q == SCAN) & ~startOfFrame) |
                                 ((state_q == REPORT) & (state_d == SCAN)));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      gflag_q  <= 1'b0;
      bflag_q  <= 1'b0;
      rep_g_q  <= 1'b0;
      rep_b_q  <= 1'b0;
      coll_g_q <= 1'b0;
      coll_b_q <= 1'b0;
      cap_x_q  <= '0;
      cap_y_q  <= '0;
      hit_x_q  <= '0;
      hit_y_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gflag_q  <= gflag_d;
      bflag_q  <= bflag_d;
      rep_g_q  <= rep_g_d;
      rep_b_q  <= rep_b_d;
      coll_g_q <= coll_g_d;
      coll_b_q <= coll_b_d;
      cap_x_q  <= cap_x_d;
      cap_y_q  <= cap_y_d;
      hit_x_q  <= hit_x_d;
      hit_y_q  <= hit_y_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (startOfFrame) state_d = SCAN;
        SCAN:    if (startOfFrame) state_d = REPORT;
        REPORT:  state_d = ((rep_g_q | rep_b_q) && (HOLDOFF_FRAMES > 0)) ? HOLDOFF : SCAN;
        HOLDOFF: if (startOfFrame && hold_q == HOLD_W'(1)) state_d = SCAN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    gflag_d  = gflag_q;
    bflag_d  = bflag_q;
    rep_g_d  = rep_g_q;
    rep_b_d  = rep_b_q;
    cap_x_d  = cap_x_q;
    cap_y_d  = cap_y_q;
    hit_x_d  = hit_x_q;
    hit_y_d  = hit_y_q;
    coll_g_d = 1'b0;
    coll_b_d = 1'b0;
    hold_d   = hold_q;
    cnt_d    = cnt_q;

    if (!enable) begin
      gflag_d = 1'b0;
      bflag_d = 1'b0;
      rep_g_d = 1'b0;
      rep_b_d = 1'b0;
    end else if (frame_start) begin
      if (state_q == SCAN) begin
        rep_g_d = gflag_q;
        rep_b_d = bflag_q;
        if (gflag_q) begin
          hit_x_d = cap_x_q;
          hit_y_d = cap_y_q;
        end
      end
      gflag_d = gate_hit;
      bflag_d = border_hit;
      if (gate_hit) begin
        cap_x_d = x_al;
        cap_y_d = y_al;
      end
    end else if (accumulate) begin
      gflag_d = gflag_q | gate_hit;
      bflag_d = bflag_q | border_hit;
      if (gate_hit && !gflag_q) begin
        cap_x_d = x_al;
        cap_y_d = y_al;
      end
    end else if (state_q == REPORT) begin
      gflag_d = 1'b0;
      bflag_d = 1'b0;
    end

    if (enable && state_q == REPORT) begin
      coll_g_d = rep_g_q;
      coll_b_d = rep_b_q;
      if (state_d == HOLDOFF) hold_d = HOLD_LOAD;
    end
    if (enable && state_q == HOLDOFF && startOfFrame) hold_d = hold_q - HOLD_W'(1);

    if (clear_count) begin
      cnt_d = '0;
    end else if (enable && state_q == REPORT && rep_g_q && cnt_q != '1) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  assign collision_gate   = coll_g_q;
  assign collision_border = coll_b_q;
  assign gate_hit_count   = cnt_q;
  assign hit_X            = hit_x_q;
  assign hit_Y            = hit_y_q;

endmodule

// File: tb/tb_gate_collision_detect.sv
// Bench for gate_collision_detect: two instances (hold-off 30 / latency 1 and
// hold-off 0 / latency 2) checked every cycle against a frame-level model.
module tb_gate_collision_detect;
  localparam int CW = 11;
  localparam int NW = 8;
  localparam int FRAME_LEN = 20;
  localparam int OFF = 0, WATCH = 1, DUE = 2, QUIET = 3;

  logic          CLK = 1'b0, RESETn = 1'b0, enable = 1'b0, startOfFrame = 1'b0;
  logic          clear_count = 1'b0, gateA = 1'b0, frog = 1'b0, border = 1'b0;
  logic [CW-1:0] cx = '0, cy = '0;

  logic          cg0, cb0, cg1, cb1;
  logic [NW-1:0] cnt0, cnt1;
  logic [CW-1:0] hx0, hy0, hx1, hy1;

  gate_collision_detect u_dut (
    .CLK(CLK), .RESETn(RESETn), .enable(enable), .startOfFrame(startOfFrame),
    .oCoord_X(cx), .oCoord_Y(cy), .gateA_draw_req(gateA), .frog_draw_req(frog),
    .border_draw_req(border), .clear_count(clear_count),
    .collision_gate(cg0), .collision_border(cb0), .gate_hit_count(cnt0),
    .hit_X(hx0), .hit_Y(hy0));

  gate_collision_detect #(.DRAW_LATENCY(2), .HOLDOFF_FRAMES(0)) u_dut0 (
    .CLK(CLK), .RESETn(RESETn), .enable(enable), .startOfFrame(startOfFrame),
    .oCoord_X(cx), .oCoord_Y(cy), .gateA_draw_req(gateA), .frog_draw_req(frog),
    .border_draw_req(border), .clear_count(clear_count),
    .collision_gate(cg1), .collision_border(cb1), .gate_hit_count(cnt1),
    .hit_X(hx1), .hit_Y(hy1));

  always #5 CLK = ~CLK;

  int compared = 0, mismatched = 0;
  int frame_no = 0;
  longint cyc = 0;
  int gp0 = 0, bp0 = 0, gp1 = 0;
  int last_gate_frame0 = -1;
  longint last_gate_cyc0 = -1, last_border_cyc0 = -2;

  // Model: per instance, what the current frame has seen and what is owed.
  int lat[2]  = '{1, 2};
  int hoff[2] = '{30, 0};
  int m_mode[2], m_quiet[2], m_cnt[2], m_hx[2], m_hy[2], m_fx[2], m_fy[2];
  bit m_fg[2], m_fb[2], m_rg[2], m_rb[2], m_eg[2], m_eb[2];
  int hist_x[4], hist_y[4];

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = OFF; m_quiet[i] = 0; m_cnt[i] = 0; m_hx[i] = 0; m_hy[i] = 0;
      m_fx[i] = 0; m_fy[i] = 0; m_fg[i] = 0; m_fb[i] = 0; m_rg[i] = 0; m_rb[i] = 0;
      m_eg[i] = 0; m_eb[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin hist_x[k] = 0; hist_y[k] = 0; end
  endtask

  task automatic note_pixel(input int i, input bit g, input bit b, input int ax, input int ay);
    if (g && !m_fg[i]) begin m_fx[i] = ax; m_fy[i] = ay; end
    m_fg[i] = m_fg[i] | g;
    m_fb[i] = m_fb[i] | b;
  endtask

  task automatic model_step(input int i);
    int ax, ay;
    bit g, b;
    ax = hist_x[lat[i]-1];
    ay = hist_y[lat[i]-1];
    g = gateA & frog;
    b = border & frog;
    m_eg[i] = 0; m_eb[i] = 0;
    if (!enable) begin
      m_mode[i] = OFF; m_fg[i] = 0; m_fb[i] = 0; m_rg[i] = 0; m_rb[i] = 0;
    end else if (m_mode[i] == OFF) begin
      if (startOfFrame) m_mode[i] = WATCH;
    end else if (m_mode[i] == WATCH) begin
      if (startOfFrame) begin
        m_rg[i] = m_fg[i]; m_rb[i] = m_fb[i];
        if (m_fg[i]) begin m_hx[i] = m_fx[i]; m_hy[i] = m_fy[i]; end
        m_fg[i] = 0; m_fb[i] = 0;
        note_pixel(i, g, b, ax, ay);
        m_mode[i] = DUE;
      end else note_pixel(i, g, b, ax, ay);
    end else if (m_mode[i] == DUE) begin
      m_eg[i] = m_rg[i]; m_eb[i] = m_rb[i];
      if (m_rg[i] && m_cnt[i] < 255) m_cnt[i]++;
      if ((m_rg[i] || m_rb[i]) && hoff[i] > 0) begin
        m_quiet[i] = hoff[i]; m_mode[i] = QUIET; m_fg[i] = 0; m_fb[i] = 0;
      end else begin
        m_mode[i] = WATCH;
        note_pixel(i, g, b, ax, ay);
      end
    end else if (startOfFrame) begin
      m_quiet[i]--;
      if (m_quiet[i] == 0) begin
        m_mode[i] = WATCH; m_fg[i] = 0; m_fb[i] = 0;
        note_pixel(i, g, b, ax, ay);
      end
    end
    if (clear_count) m_cnt[i] = 0;
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (!RESETn) model_reset();
    else begin
      model_step(0);
      model_step(1);
      for (int k = 3; k > 0; k--) begin hist_x[k] = hist_x[k-1]; hist_y[k] = hist_y[k-1]; end
      hist_x[0] = int'(cx); hist_y[0] = int'(cy);
    end
    #1;
    check("gate0", cg0, m_eg[0]);   check("border0", cb0, m_eb[0]);
    check("count0", cnt0, m_cnt[0]); check("hitx0", hx0, m_hx[0]); check("hity0", hy0, m_hy[0]);
    check("gate1", cg1, m_eg[1]);   check("border1", cb1, m_eb[1]);
    check("count1", cnt1, m_cnt[1]); check("hitx1", hx1, m_hx[1]); check("hity1", hy1, m_hy[1]);
    if (cg0) begin gp0++; last_gate_frame0 = frame_no; last_gate_cyc0 = cyc; end
    if (cb0) begin bp0++; last_border_cyc0 = cyc; end
    if (cg1) gp1++;
  end

  // One frame of FRAME_LEN cycles; gate overlap from pixel 5, border overlap from pixel 10.
  task automatic run_frame(input int gate_n, input int bord_n, input bit sof_hit,
                           input bit rnd, input int clr_at, input int en_off_at);
    for (int c = 0; c < FRAME_LEN; c++) begin
      @(negedge CLK);
      startOfFrame = (c == 0);
      if (c == 0) frame_no++;
      if (rnd) begin
        cx = CW'($urandom_range(0, 2047));
        cy = CW'($urandom_range(0, 2047));
        gateA = ($urandom % 4 == 0);
        frog = ($urandom % 3 == 0);
        border = ($urandom % 5 == 0);
        clear_count = ($urandom % 60 == 0);
        enable = ($urandom % 400 != 0);
      end else begin
        gateA = (c >= 5 && c < 5 + gate_n) || (sof_hit && c == 0);
        border = (c >= 10 && c < 10 + bord_n);
        frog = gateA | border;
        clear_count = (c == clr_at);
        if (en_off_at >= 0 && c >= en_off_at) enable = 1'b0;
      end
    end
  endtask

  initial begin
    int p, pf1, b;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_gate", cg0, 0); check("rst_border", cb0, 0); check("rst_count", cnt0, 0);
    check("rst_hitx", hx0, 0); check("rst_hity", hy0, 0);
    RESETn = 1'b1;
    enable = 1'b1; cx = 100; cy = 50;

    // Single overlap frame, reported at the next frame start.
    run_frame(3, 0, 0, 0, -1, -1);
    p = gp0;
    run_frame(0, 0, 0, 0, -1, -1);
    check("t1_pulses", gp0 - p, 1);
    check("t1_count", cnt0, 1);
    check("t1_hitx", hx0, 100); check("t1_hity", hy0, 50);
    check("t1_hitx_lat2", hx1, 100);
    pf1 = last_gate_frame0;

    // Continuous overlap: hold-off spaces the reports 31 frame starts apart.
    p = gp0;
    repeat (40) run_frame(3, 0, 0, 0, -1, -1);
    check("t2_pulses", gp0 - p, 1);
    check("t2_gap", last_gate_frame0 - pf1, 31);
    check("t2_count", cnt0, 2);
    repeat (25) run_frame(0, 0, 0, 0, -1, -1);

    // Gate and border in one frame.
    p = gp0; b = bp0;
    run_frame(3, 2, 0, 0, -1, -1);
    run_frame(0, 0, 0, 0, -1, -1);
    check("t3_gate", gp0 - p, 1); check("t3_border", bp0 - b, 1);
    check("t3_same_cycle", last_border_cyc0, last_gate_cyc0);
    check("t3_count", cnt0, 3);
    repeat (33) run_frame(0, 0, 0, 0, -1, -1);

    // Overlap on the frame-start pixel belongs to the new frame.
    cx = 300; cy = 70;
    p = gp0;
    run_frame(0, 0, 1, 0, -1, -1);
    check("t5_not_current", gp0 - p, 0);
    run_frame(0, 0, 0, 0, -1, -1);
    check("t5_next", gp0 - p, 1);
    check("t5_hitx", hx0, 300); check("t5_hity", hy0, 70);
    repeat (33) run_frame(0, 0, 0, 0, -1, -1);

    // Enable dropped mid-frame after an overlap.
    cx = 200; cy = 60;
    p = gp0;
    run_frame(3, 0, 0, 0, -1, 12);
    run_frame(0, 0, 0, 0, -1, -1);
    check("t6_no_pulse", gp0 - p, 0);
    check("t6_count", cnt0, 4);
    check("t6_hitx", hx0, 300); check("t6_hity", hy0, 70);
    enable = 1'b1;
    run_frame(0, 0, 0, 0, -1, -1);
    run_frame(3, 0, 0, 0, -1, -1);
    run_frame(0, 0, 0, 0, -1, -1);
    check("t6_count_after", cnt0, 5);
    check("t6_hitx_after", hx0, 200);
    repeat (3) run_frame(0, 0, 0, 0, -1, -1);

    // Reset in the middle of a hold-off.
    @(negedge CLK); RESETn = 1'b0; startOfFrame = 1'b0; gateA = 0; frog = 0; border = 0;
    #1;
    check("t6r_gate", cg0, 0); check("t6r_count", cnt0, 0);
    check("t6r_hitx", hx0, 0); check("t6r_hity", hy0, 0); check("t6r_count1", cnt1, 0);
    @(negedge CLK); RESETn = 1'b1;

    // Saturation and clear priority on the no-hold-off instance.
    repeat (260) run_frame(1, 0, 0, 0, -1, -1);
    run_frame(0, 0, 0, 0, -1, -1);
    check("t4_saturate", cnt1, 255);
    run_frame(1, 0, 0, 0, 1, -1);
    p = gp1;
    run_frame(1, 0, 0, 0, 1, -1);
    check("t4_pulse_with_clear", gp1 - p, 1);
    check("t4_clear_wins", cnt1, 0);
    run_frame(0, 0, 0, 0, -1, -1);
    check("t4_after_clear", cnt1, 1);

    repeat (80) run_frame(0, 0, 0, 1, -1, -1);
    enable = 1'b1; clear_count = 1'b0;
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
